aes16_round_sequencer: RTL and testbench

//  Iterative controller for the 16-bit AES datapath: one `rounds` instance is reused over
//  NUM_ROUNDS clock cycles instead of an unrolled ten-instance chain.

---
 rtl/aes16_pkg.sv | 81 ++++++++
 rtl/rounds.sv | 76 +++++++
 rtl/aes16_round_sequencer.sv | 162 ++++++++++++++++
 tb/tb_aes16_round_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes16_pkg.sv
// ---------------------------------------------------------------------------
// aes16_pkg
//   Shared types, sizes and nibble-level helpers for the 16-bit AES datapath.
//   The cipher works on four 4-bit nibbles arranged as a 2x2 state
//   (columns {n0,n1} and {n2,n3}), with arithmetic in GF(2^4) modulo
//   x^4 + x + 1.
//
//   Contents:
//     AES16_DATA_W, AES16_CNT_W, AES16_NUM_ROUNDS  sizing constants
//     aes16_seq_state_e                            sequencer FSM states
//     aes16_word_t                                 16-bit block/key word
//     aes16_sbox / aes16_xtime / aes16_rcon        nibble helpers
// ---------------------------------------------------------------------------
package aes16_pkg;

    localparam int AES16_DATA_W     = 16;
    localparam int AES16_CNT_W      = 4;
    localparam int AES16_NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes16_seq_state_e;

    typedef logic [15:0] aes16_word_t;

    // 4-bit substitution box.
    function automatic logic [3:0] aes16_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;
            4'h1: y = 4'h4;
            4'h2: y = 4'hD;
            4'h3: y = 4'h1;
            4'h4: y = 4'h2;
            4'h5: y = 4'hF;
            4'h6: y = 4'hB;
            4'h7: y = 4'h8;
            4'h8: y = 4'h3;
            4'h9: y = 4'hA;
            4'hA: y = 4'h6;
            4'hB: y = 4'hC;
            4'hC: y = 4'h5;
            4'hD: y = 4'h9;
            4'hE: y = 4'h0;
            default: y = 4'h7;
        endcase
        return y;
    endfunction

    // Multiply by x in GF(2^4); x^4 folds back to x + 1.
    function automatic logic [3:0] aes16_xtime(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    endfunction

    // Round constant for round index r: x^r in GF(2^4).
    function automatic logic [3:0] aes16_rcon(input logic [3:0] r);
        logic [3:0] c;
        case (r)
            4'd0:  c = 4'h1;
            4'd1:  c = 4'h2;
            4'd2:  c = 4'h4;
            4'd3:  c = 4'h8;
            4'd4:  c = 4'h3;
            4'd5:  c = 4'h6;
            4'd6:  c = 4'hC;
            4'd7:  c = 4'hB;
            4'd8:  c = 4'h5;
            4'd9:  c = 4'hA;
            4'd10: c = 4'h7;
            4'd11: c = 4'hE;
            4'd12: c = 4'hF;
            4'd13: c = 4'hD;
            4'd14: c = 4'h9;
            default: c = 4'h0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rounds.sv
// ---------------------------------------------------------------------------
// rounds
//   One 16-bit AES round plus one step of the key schedule, purely
//   combinational. The sequencer feeds it back on itself once per clock.
//
//   Round:  NibbleSub -> ShiftRow (swap n1/n3) -> MixColumn (skipped on the
//           last round) -> AddRoundKey with the freshly expanded key.
//   Key:    w4 = k0 ^ S(k3) ^ rcon(count); w5 = k1 ^ w4; w6 = k2 ^ w5;
//           w7 = k3 ^ w6.
//
//   Ports:
//     clk      in   1   kept for interface compatibility; unused here
//     count    in   4   round index 0..NUM_ROUNDS-1
//     code     in   16  state entering the round
//     keyin    in   16  previous round key
//     altered  out  16  state leaving the round
//     keyout   out  16  round key used by this round
// ---------------------------------------------------------------------------
module rounds
    import aes16_pkg::*;
#(
    parameter int NUM_ROUNDS = AES16_NUM_ROUNDS
) (
    input  logic                   clk,
    input  logic [AES16_CNT_W-1:0] count,
    input  aes16_word_t            code,
    input  aes16_word_t            keyin,
    output aes16_word_t            altered,
    output aes16_word_t            keyout
);

    localparam logic [AES16_CNT_W-1:0] LAST_CNT = AES16_CNT_W'(NUM_ROUNDS - 1);

    // The round is combinational; clk only exists so pipelined variants can
    // drop in without changing the instantiation.
    logic unused_clk;
    assign unused_clk = clk;

    // Key expansion.
    logic [3:0] w4, w5, w6, w7;
    assign w4 = keyin[15:12] ^ aes16_sbox(keyin[3:0]) ^ aes16_rcon(count);
    assign w5 = keyin[11:8]  ^ w4;
    assign w6 = keyin[7:4]   ^ w5;
    assign w7 = keyin[3:0]   ^ w6;
    assign keyout = {w4, w5, w6, w7};

    // NibbleSub.
    logic [3:0] s0, s1, s2, s3;
    assign s0 = aes16_sbox(code[15:12]);
    assign s1 = aes16_sbox(code[11:8]);
    assign s2 = aes16_sbox(code[7:4]);
    assign s3 = aes16_sbox(code[3:0]);

    // ShiftRow: the second row {n1,n3} rotates by one, i.e. n1 and n3 swap.
    logic [3:0] t0, t1, t2, t3;
    assign t0 = s0;
    assign t1 = s3;
    assign t2 = s2;
    assign t3 = s1;

    // MixColumn with matrix [[3,2],[2,3]] on each column {t0,t1}, {t2,t3}.
    aes16_word_t mixed;
    aes16_word_t shifted;
    assign shifted = {t0, t1, t2, t3};
    assign mixed = {
        aes16_xtime(t0) ^ t0 ^ aes16_xtime(t1),
        aes16_xtime(t0) ^ aes16_xtime(t1) ^ t1,
        aes16_xtime(t2) ^ t2 ^ aes16_xtime(t3),
        aes16_xtime(t2) ^ aes16_xtime(t3) ^ t3
    };

    // The final round omits MixColumn so the cipher stays invertible with
    // the same structure in the decrypt direction.
    assign altered = ((count == LAST_CNT) ? shifted : mixed) ^ keyout;

endmodule

// File: rtl/aes16_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes16_round_sequencer
//   Iterative controller for the 16-bit AES datapath. A single `rounds`
//   instance is reused for NUM_ROUNDS cycles per block. One block in flight.
//
//   Optional feature macro: FINAL_KEY_OUT_EN
//     defined   -> adds key_last[15:0], the last round key, loaded together
//                  with codeout (seed for the decrypt key schedule)
//     undefined -> no key_last port
//
//   Ports:
//     clk        in   1   rising-edge clock
//     rst_n      in   1   synchronous active-low reset
//     in_valid   in   1   source presents codein/key
//     in_ready   out  1   high only in IDLE
//     codein     in   16  plaintext, sampled on accept
//     key        in   16  cipher key, sampled on accept
//     out_valid  out  1   codeout holds a finished block
//     out_ready  in   1   sink takes codeout
//     codeout    out  16  ciphertext, stable while out_valid
//     busy       out  1   high in RUN and DONE
//     round_idx  out  4   current round in RUN, 0 otherwise
//     key_last   out  16  (FINAL_KEY_OUT_EN only) last round key
// ---------------------------------------------------------------------------
module aes16_round_sequencer
    import aes16_pkg::*;
#(
    parameter int NUM_ROUNDS = AES16_NUM_ROUNDS,
    parameter int DATA_W     = AES16_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      codein,
    input  logic [DATA_W-1:0]      key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      codeout,
    output logic                   busy,
    output logic [AES16_CNT_W-1:0] round_idx
`ifdef FINAL_KEY_OUT_EN
    ,
    output logic [DATA_W-1:0]      key_last
`endif
);

    // Elaboration-time parameter guards.
    if (DATA_W != AES16_DATA_W) begin : g_bad_data_w
        $error("aes16_round_sequencer: DATA_W must be 16");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_num_rounds
        $error("aes16_round_sequencer: NUM_ROUNDS must be in 1..15");
    end

    localparam logic [AES16_CNT_W-1:0] LAST_CNT = AES16_CNT_W'(NUM_ROUNDS - 1);

    aes16_seq_state_e       state, state_nxt;
    logic [AES16_CNT_W-1:0] cnt;
    aes16_word_t            data_r;
    aes16_word_t            key_r;
    aes16_word_t            altered;
    aes16_word_t            keyout;

    logic accept;
    logic last_round;
    logic drain;

    rounds #(
        .NUM_ROUNDS(NUM_ROUNDS)
    ) u_rounds (
        .clk    (clk),
        .count  (cnt),
        .code   (data_r),
        .keyin  (key_r),
        .altered(altered),
        .keyout (keyout)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and transfer strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_nxt  = state;
        accept     = 1'b0;
        last_round = 1'b0;
        drain      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    last_round = 1'b1;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                // No accept in this cycle: IDLE must be visited first.
                if (out_ready) begin
                    drain     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and counter.
    always_ff @(posedge clk) begin
        // NOTE: these are plain flops, not a memory array, so resetting them
        // is cheap and makes the post-reset outputs fully defined.
        if (!rst_n) begin
            cnt       <= '0;
            data_r    <= '0;
            key_r     <= '0;
            codeout   <= '0;
            out_valid <= 1'b0;
`ifdef FINAL_KEY_OUT_EN
            key_last  <= '0;
`endif
        end else if (accept) begin
            data_r <= codein ^ key;   // initial key whitening
            key_r  <= key;
            cnt    <= '0;
        end else if (state == RUN) begin
            data_r <= altered;
            key_r  <= keyout;
            if (last_round) begin
                codeout   <= altered;
                out_valid <= 1'b1;
`ifdef FINAL_KEY_OUT_EN
                key_last  <= keyout;
`endif
            end else begin
                cnt <= cnt + AES16_CNT_W'(1);
            end
        end else if (drain) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign round_idx = (state == RUN) ? cnt : '0;

endmodule

// File: tb/tb_aes16_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes16_round_sequencer
//   Self-checking bench for aes16_round_sequencer. The reference is an
//   unrolled encryption written over nibble arrays with table S-box lookups
//   and carry-less GF(2^4) multiplication. Define FINAL_KEY_OUT_EN to also
//   check key_last.
// ---------------------------------------------------------------------------
module tb_aes16_round_sequencer;
    import aes16_pkg::*;

    localparam int NR     = AES16_NUM_ROUNDS;
    localparam int BUDGET = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] codein;
    logic [15:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] codeout;
    logic        busy;
    logic [3:0]  round_idx;
`ifdef FINAL_KEY_OUT_EN
    logic [15:0] key_last;
`endif

    always #5 clk = ~clk;

    aes16_round_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .codein   (codein),
        .key      (key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .codeout  (codeout),
        .busy     (busy),
        .round_idx(round_idx)
`ifdef FINAL_KEY_OUT_EN
        ,
        .key_last (key_last)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [63:0] SBOX_TBL = 64'h7095C6A38BF21D4E;  // entry 0 in bits [3:0]

    function automatic logic [3:0] sb(input logic [3:0] x);
        return SBOX_TBL[int'(x) * 4 +: 4];
    endfunction

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (int'(a) << i);
        for (int bi = 6; bi >= 4; bi--)
            if (p[bi]) p = p ^ (32'h13 << (bi - 4));
        return p[3:0];
    endfunction

    typedef struct packed {
        logic [15:0] code;
        logic [15:0] key;
    } res_t;

    function automatic res_t golden(input logic [15:0] pt, input logic [15:0] k);
        logic [3:0] s [4];
        logic [3:0] w [4];
        logic [3:0] rc, t, a, b;
        res_t r;
        for (int i = 0; i < 4; i++) begin
            w[i] = k[15 - 4*i -: 4];
            s[i] = pt[15 - 4*i -: 4] ^ w[i];
        end
        rc = 4'h1;
        for (int rnd = 0; rnd < NR; rnd++) begin
            w[0] = w[0] ^ sb(w[3]) ^ rc;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rc = gmul(rc, 4'h2);
            for (int i = 0; i < 4; i++) s[i] = sb(s[i]);
            t = s[1]; s[1] = s[3]; s[3] = t;
            if (rnd != NR - 1) begin
                for (int c = 0; c < 2; c++) begin
                    a = s[2*c];
                    b = s[2*c + 1];
                    s[2*c]     = gmul(4'h3, a) ^ gmul(4'h2, b);
                    s[2*c + 1] = gmul(4'h2, a) ^ gmul(4'h3, b);
                end
            end
            for (int i = 0; i < 4; i++) s[i] = s[i] ^ w[i];
        end
        r.code = {s[0], s[1], s[2], s[3]};
        r.key  = {w[0], w[1], w[2], w[3]};
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!out_valid && n < BUDGET) begin
            tick();
            n++;
        end
    endtask

    task automatic check_result(input string tag, input res_t exp);
        check({tag, " codeout"}, 32'(codeout), 32'(exp.code));
`ifdef FINAL_KEY_OUT_EN
        check({tag, " key_last"}, 32'(key_last), 32'(exp.key));
`endif
    endtask

    // Full block with out_ready=1 throughout; checks latency and round_idx steps.
    task automatic run_block(input logic [15:0] pt, input logic [15:0] k, input res_t exp,
                             input string tag);
        int n;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'(1));
        codein    = pt;
        key       = k;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        codein   = 16'($urandom);
        key      = 16'($urandom);
        check({tag, " busy"}, 32'(busy), 32'(1));
        check({tag, " round_idx0"}, 32'(round_idx), 32'(0));
        n = 0;
        while (!out_valid && n < BUDGET) begin
            tick();
            n++;
            if (!out_valid) check({tag, " round_idx"}, 32'(round_idx), 32'(n));
        end
        check({tag, " latency"}, 32'(n), 32'(NR));
        check_result(tag, exp);
        tick();
        check({tag, " out_valid drop"}, 32'(out_valid), 32'(0));
        check({tag, " back to idle"}, 32'(in_ready), 32'(1));
    endtask

    typedef struct {
        logic [15:0] codein;
        logic [15:0] key;
        res_t        exp;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [6];
        logic [15:0] pts  [6];
        logic [15:0] keys [6];
        res_t        ra, rb, r_hold;
        int          n;
        bit          saw_valid;
        int          acc;
        int          t_out [$];
        logic [15:0] c_out [$];
        logic [15:0] k_out [$];

        pts  = '{16'h1234, 16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'hDEAD};
        keys = '{16'hABCD, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hBEEF};
        for (int i = 0; i < 6; i++) begin
            vecs[i].codein = pts[i];
            vecs[i].key    = keys[i];
            vecs[i].exp    = golden(pts[i], keys[i]);
        end

        // ---- 1: reset ----
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        codein    = '0;
        key       = '0;
        repeat (3) tick();
        check("reset in_ready", 32'(in_ready), 32'(1));
        check("reset out_valid", 32'(out_valid), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset codeout", 32'(codeout), 32'(0));
        check("reset round_idx", 32'(round_idx), 32'(0));
        rst_n = 1'b1;
        tick();

        // ---- 2: table-driven single blocks ----
        for (int i = 0; i < 6; i++)
            run_block(vecs[i].codein, vecs[i].key, vecs[i].exp, $sformatf("vec%0d", i));

        // ---- 3: backpressure ----
        r_hold    = golden(16'h5A5A, 16'h0F0F);
        codein    = 16'h5A5A;
        key       = 16'h0F0F;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_out_valid(n);
        check("bp latency", 32'(n), 32'(NR));
        check_result("bp", r_hold);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            codein   = 16'($urandom);
            key      = 16'($urandom);
            tick();
            check("bp out_valid held", 32'(out_valid), 32'(1));
            check("bp codeout held", 32'(codeout), 32'(r_hold.code));
            check("bp in_ready low", 32'(in_ready), 32'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp release idle", 32'(in_ready), 32'(1));
        check("bp release out_valid", 32'(out_valid), 32'(0));

        // ---- 4: input presented during RUN ----
        ra       = golden(16'h1234, 16'hABCD);
        rb       = golden(16'hFFFF, 16'h0000);
        codein   = 16'h1234;
        key      = 16'hABCD;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd3 && n < BUDGET) begin
            tick();
            n++;
        end
        check("run-input reached round 3", 32'(round_idx), 32'(3));
        codein   = 16'hFFFF;
        key      = 16'h0000;
        in_valid = 1'b1;
        wait_out_valid(n);
        check("run-input remaining rounds", 32'(n), 32'(NR - 3));
        check_result("run-input first", ra);
        check("run-input in_ready in DONE", 32'(in_ready), 32'(0));
        tick();
        check("run-input idle before accept", 32'(busy), 32'(0));
        tick();
        in_valid = 1'b0;
        check("run-input second accepted", 32'(busy), 32'(1));
        check("run-input second round_idx", 32'(round_idx), 32'(0));
        wait_out_valid(n);
        check("run-input second latency", 32'(n), 32'(NR));
        check_result("run-input second", rb);
        tick();

        // ---- 5: reset mid-block ----
        codein   = 16'h1234;
        key      = 16'hABCD;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd4 && n < BUDGET) begin
            tick();
            n++;
        end
        check("midreset reached round 4", 32'(round_idx), 32'(4));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset busy", 32'(busy), 32'(0));
        check("midreset in_ready", 32'(in_ready), 32'(1));
        check("midreset out_valid", 32'(out_valid), 32'(0));
        check("midreset round_idx", 32'(round_idx), 32'(0));
        check("midreset codeout", 32'(codeout), 32'(0));
        saw_valid = 1'b0;
        for (int i = 0; i < NR + 4; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        check("midreset no partial out_valid", 32'(saw_valid), 32'(0));
        run_block(16'h0000, 16'h0000, golden(16'h0000, 16'h0000), "after-reset");

        // ---- 6: back-to-back blocks ----
        ra        = golden(16'h0000, 16'hFFFF);
        rb        = golden(16'hFFFF, 16'h0000);
        acc       = 0;
        codein    = 16'h0000;
        key       = 16'hFFFF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            if (in_ready && in_valid) acc++;
            tick();
            if (acc == 1) begin
                codein = 16'hFFFF;
                key    = 16'h0000;
            end
            if (acc == 2) in_valid = 1'b0;
            if (out_valid) begin
                t_out.push_back(cyc);
                c_out.push_back(codeout);
`ifdef FINAL_KEY_OUT_EN
                k_out.push_back(key_last);
`else
                k_out.push_back(16'h0000);
`endif
            end
        end
        check("b2b result count", 32'(t_out.size()), 32'(2));
        if (t_out.size() == 2) begin
            check("b2b first latency", 32'(t_out[0]), 32'(NR + 1));
            check("b2b spacing", 32'(t_out[1] - t_out[0]), 32'(NR + 2));
            check("b2b first codeout", 32'(c_out[0]), 32'(ra.code));
            check("b2b second codeout", 32'(c_out[1]), 32'(rb.code));
`ifdef FINAL_KEY_OUT_EN
            check("b2b first key_last", 32'(k_out[0]), 32'(ra.key));
            check("b2b second key_last", 32'(k_out[1]), 32'(rb.key));
`endif
        end

        // ---- 7: randomized blocks with random gaps and backpressure ----
        for (int i = 0; i < 16; i++) begin
            logic [15:0] pt, k;
            pt        = 16'($urandom);
            k         = 16'($urandom);
            r_hold    = golden(pt, k);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            check("rand in_ready", 32'(in_ready), 32'(1));
            codein   = pt;
            key      = k;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            wait_out_valid(n);
            check("rand latency", 32'(n), 32'(NR));
            check_result($sformatf("rand%0d", i), r_hold);
            repeat ($urandom_range(0, 3)) tick();
            check("rand held codeout", 32'(codeout), 32'(r_hold.code));
            check("rand held out_valid", 32'(out_valid), 32'(1));
            out_ready = 1'b1;
            tick();
            check("rand drained", 32'(out_valid), 32'(0));
        end
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
